// File: rtl/branch_resolve_unit.sv
// Two-stage branch decision unit: half-width compares in stage A, combine/direction/mispredict in stage B.
// Optional statistics counters are enabled with `define BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode_6_to_2,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic             pred_taken,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             branch_taken,
  output logic             mispredict,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned HALF = XLEN / 2;

  localparam logic [1:0] CLS_BRANCH = 2'd0;
  localparam logic [1:0] CLS_JAL    = 2'd1;
  localparam logic [1:0] CLS_JALR   = 2'd2;
  localparam logic [1:0] CLS_OTHER  = 2'd3;

  logic             a_valid;
  logic             a_eq_lo, a_eq_hi, a_ltu_lo, a_ltu_hi;
  logic             a_s1, a_s2;
  logic [2:0]       a_funct3;
  logic [1:0]       a_cls;
  logic             a_pred;
  logic [TAG_W-1:0] a_tag;

  logic       adv_a, adv_b;
  logic [1:0] cls_c;
  logic       eq_c, ltu_c, lt_c, taken_c;

  // Backpressure ripples from the consumer straight to the producer (no skid buffer)
  assign adv_b    = !out_valid || out_ready;
  assign adv_a    = !a_valid || adv_b;
  assign in_ready = flush || adv_a;

  // Opcode classification
  always_comb begin
    cls_c = CLS_OTHER;
    case (opcode_6_to_2)
      5'b11000: cls_c = CLS_BRANCH;
      5'b11011: cls_c = CLS_JAL;
      5'b11001: cls_c = CLS_JALR;
      default:  cls_c = CLS_OTHER;
    endcase
  end

  // Stage A: half-width unsigned compares plus sign bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid  <= 1'b0;
      a_eq_lo  <= 1'b0;
      a_eq_hi  <= 1'b0;
      a_ltu_lo <= 1'b0;
      a_ltu_hi <= 1'b0;
      a_s1     <= 1'b0;
      a_s2     <= 1'b0;
      a_funct3 <= 3'd0;
      a_cls    <= CLS_OTHER;
      a_pred   <= 1'b0;
      a_tag    <= '0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (adv_a) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_eq_lo  <= (rs1[HALF-1:0] == rs2[HALF-1:0]);
        a_eq_hi  <= (rs1[XLEN-1:HALF] == rs2[XLEN-1:HALF]);
        a_ltu_lo <= (rs1[HALF-1:0] < rs2[HALF-1:0]);
        a_ltu_hi <= (rs1[XLEN-1:HALF] < rs2[XLEN-1:HALF]);
        a_s1     <= rs1[XLEN-1];
        a_s2     <= rs2[XLEN-1];
        a_funct3 <= funct3;
        a_cls    <= cls_c;
        a_pred   <= pred_taken;
        a_tag    <= in_tag;
      end
    end
  end

  // Stage B combine: full-width compare results and resolved direction
  always_comb begin
    eq_c    = a_eq_hi && a_eq_lo;
    ltu_c   = a_ltu_hi || (a_eq_hi && a_ltu_lo);
    lt_c    = (a_s1 != a_s2) ? a_s1 : ltu_c;
    taken_c = 1'b0;
    case (a_cls)
      CLS_BRANCH: begin
        case (a_funct3)
          3'b000:  taken_c = eq_c;
          3'b001:  taken_c = !eq_c;
          3'b100:  taken_c = lt_c;
          3'b101:  taken_c = !lt_c;
          3'b110:  taken_c = ltu_c;
          3'b111:  taken_c = !ltu_c;
          default: taken_c = 1'b0;
        endcase
      end
      CLS_JAL, CLS_JALR: taken_c = 1'b1;
      default:           taken_c = 1'b0;
    endcase
  end

  // Output stage; payload only moves when a valid result advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      branch_taken <= 1'b0;
      mispredict   <= 1'b0;
      out_tag      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv_b) begin
      out_valid <= a_valid;
      if (a_valid) begin
        branch_taken <= taken_c;
        mispredict   <= taken_c ^ a_pred;
        out_tag      <= a_tag;
      end
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic out_ctrl;

  // Control-transfer flag travels with the output payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ctrl <= 1'b0;
    end else if (!flush && adv_b && a_valid) begin
      out_ctrl <= (a_cls != CLS_OTHER);
    end
  end

  // Counters observe output handshakes only; flush does not touch them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count   <= '0;
      miss_count <= '0;
    end else if (out_valid && out_ready) begin
      if (out_ctrl)   br_count   <= br_count + CNT_W'(1);
      if (mispredict) miss_count <= miss_count + CNT_W'(1);
    end
  end
`else
  assign br_count   = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expectations on acceptance,
// a monitor pops and compares on every output handshake.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode_6_to_2;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        pred_taken;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic        branch_taken;
  logic        mispredict;
  logic [3:0]  out_tag;
  logic [31:0] br_count, miss_count;

  typedef struct packed {
    logic [3:0] tag;
    logic       taken;
    logic       mis;
    logic       lat;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic exp_taken, exp_mis, exp_lat, expect_ready;

  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [4:0] OP_OP   = 5'b01100;

  branch_resolve_unit #(.XLEN(32), .TAG_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode_6_to_2(opcode_6_to_2), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .pred_taken(pred_taken), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .branch_taken(branch_taken), .mispredict(mispredict), .out_tag(out_tag),
    .br_count(br_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Record the expected result whenever the DUT takes an input
  always @(negedge clk) begin
    if (!rst && !flush && in_valid && in_ready)
      exp_q.push_back('{tag: in_tag, taken: exp_taken, mis: exp_mis, lat: exp_lat, cyc: cyc});
  end

  // Compare every output handshake against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output tag=%0h with no pending transaction", out_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        chk("branch_taken", 32'(branch_taken), 32'(e.taken));
        chk("mispredict", 32'(mispredict), 32'(e.mis));
        if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic p, input logic [3:0] t,
                         input logic et, input logic em, input logic lat);
    in_valid      = 1'b1;
    opcode_6_to_2 = op;
    funct3        = f3;
    rs1           = a;
    rs2           = b;
    pred_taken    = p;
    in_tag        = t;
    exp_taken     = et;
    exp_mis       = em;
    exp_lat       = lat;
  endtask

  task automatic wait_accept;
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (n == 0 && expect_ready) chk("in_ready_no_stall", 32'(in_ready), 32'd1);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic p, input logic [3:0] t,
                      input logic et, input logic em, input logic lat);
    present(op, f3, a, b, p, t, et, em, lat);
    wait_accept();
  endtask

  task automatic drain;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_counters(input logic [31:0] br, input logic [31:0] miss);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("br_count", br_count, br);
    chk("miss_count", miss_count, miss);
`else
    chk("br_count_tied", br_count, 32'd0 & br);
    chk("miss_count_tied", miss_count, 32'd0 & miss);
`endif
  endtask

  logic [3:0] hold_tag;
  logic       hold_taken, hold_mis;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode_6_to_2 = '0; funct3 = '0; rs1 = '0; rs2 = '0; pred_taken = 1'b0; in_tag = '0;
    exp_taken = 1'b0; exp_mis = 1'b0; exp_lat = 1'b0; expect_ready = 1'b0;
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_taken", 32'(branch_taken), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk_counters(32'd0, 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Signed vs unsigned less-than on a negative operand
    out_ready = 1'b1; expect_ready = 1'b1;
    send(OP_BR, 3'b100, 32'hFFFF_FFF8, 32'h0000_000C, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1);
    send(OP_BR, 3'b110, 32'hFFFF_FFF8, 32'h0000_000C, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    drain();
    chk_counters(32'd2, 32'd1);

    // Back-to-back BEQ stream, equal operands on even tags
    send(OP_BR, 3'b000, 32'h0000_1234, 32'h0000_1235, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
    send(OP_BR, 3'b000, 32'h0000_1234, 32'h0000_1234, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1);
    send(OP_BR, 3'b000, 32'h0000_1234, 32'h0001_1234, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    send(OP_BR, 3'b000, 32'h0000_1234, 32'h0000_1234, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1);
    drain();

    // Stall with the pipe full; 0x80000000 vs 0x7FFFFFFF boundary
    out_ready = 1'b0; expect_ready = 1'b0;
    send(OP_BR, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
    send(OP_BR, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    present(OP_BR, 3'b001, 32'h0000_0055, 32'h0000_0055, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        hold_tag = out_tag; hold_taken = branch_taken; hold_mis = mispredict;
        chk("stall_first_tag", 32'(out_tag), 32'd5);
        chk("stall_first_taken", 32'(branch_taken), 32'd0);
        chk("stall_first_mis", 32'(mispredict), 32'd1);
      end else begin
        chk("stall_hold_tag", 32'(out_tag), 32'(hold_tag));
        chk("stall_hold_taken", 32'(branch_taken), 32'(hold_taken));
        chk("stall_hold_mis", 32'(mispredict), 32'(hold_mis));
      end
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Flush with two in flight and one presented
    out_ready = 1'b0;
    send(OP_BR, 3'b000, 32'h0000_0001, 32'h0000_0001, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    send(OP_BR, 3'b100, 32'h0000_0000, 32'h0000_0001, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0);
    present(OP_BR, 3'b000, 32'h0000_0002, 32'h0000_0002, 1'b0, 4'd10, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("in_ready_flush", 32'(in_ready), 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(OP_BR, 3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 4'd11, 1'b1, 1'b1, 1'b1);
    drain();

    // Jumps, non-control op, reserved funct3
    send(OP_JAL, 3'bxxx, 32'h0000_0000, 32'h0000_0009, 1'b1, 4'd12, 1'b1, 1'b0, 1'b1);
    send(OP_JALR, 3'b010, 32'h0000_0003, 32'h0000_0009, 1'b0, 4'd13, 1'b1, 1'b1, 1'b1);
    send(OP_OP, 3'b000, 32'h0000_0004, 32'h0000_0004, 1'b1, 4'd14, 1'b0, 1'b1, 1'b1);
    send(OP_BR, 3'b010, 32'h0000_0004, 32'h0000_0004, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1);
    drain();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(OP_BR, 3'b000, 32'h0000_0007, 32'h0000_0007, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
    send(OP_BR, 3'b000, 32'h0000_0007, 32'h0000_0008, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    step();
    #2;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_taken", 32'(branch_taken), 32'd0);
    chk("async_rst_mis", 32'(mispredict), 32'd0);
    chk("async_rst_tag", 32'(out_tag), 32'd0);
    chk_counters(32'd0, 32'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst2", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(OP_BR, 3'b001, 32'h0000_0007, 32'h0000_0008, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined branch decision unit for the Steel Core execute path.
- Generalises the combinational branch comparator to configurable XLEN and a fixed 2-stage compare. It adds valid/ready flow control, a transaction tag, a pipeline flush, and misprediction detection against a front-end prediction.
- Sits between decode/operand-read and the fetch redirect logic.

Parameters:
- XLEN, 32, operand width; even, ≥ 8; split into two halves of XLEN/2 for stage-A comparison.
- TAG_W, 4, width of the opaque tag carried alongside each transaction.
- CNT_W, 32, width of statistic counters (optional feature only).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous pipeline kill.
- IN_VALID  in  1  input transaction valid.
- IN_READY  out  1  unit can accept input this cycle.
- OPCODE_6_TO_2  in  5  instruction opcode bits [6:2].
- FUNCT3  in  3  branch condition select.
- RS1  in  XLEN  first operand.
- RS2  in  XLEN  second operand.
- PRED_TAKEN  in  1  front-end predicted direction.
- IN_TAG  in  TAG_W  transaction tag.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- BRANCH_TAKEN  out  1  resolved direction.
- MISPREDICT  out  1  resolved direction != PRED_TAKEN.
- OUT_TAG  out  TAG_W  tag of the result.
- BR_COUNT  out  CNT_W  resolved control-transfer count (optional feature only).
- MISS_COUNT  out  CNT_W  misprediction count (optional feature only).

Behaviour:
- Reset (async, any time, including mid-transfer):
  - both stage valids = 0.
  - OUT_VALID, BRANCH_TAKEN, MISPREDICT, OUT_TAG = 0.
  - counters = 0.
  - IN_READY = 1 once reset deasserts.
- Handshake:
  - Input is accepted when IN_VALID & IN_READY at a rising edge.
  - Output is consumed when OUT_VALID & OUT_READY.
  - Output payload is held stable while OUT_VALID & !OUT_READY.
- Flow control:
  - advB = !vB | OUT_READY.
  - advA = !vA | advB.
  - IN_READY = advA (combinational from OUT_READY, no skid buffer).
  - Full throughput: 1 transaction/cycle when OUT_READY is held 1.
- Latency: exactly 2 cycles from acceptance to OUT_VALID with no stall.
- Stage A registers:
  - eq_lo, eq_hi, ltu_lo, ltu_hi: unsigned half compares.
  - s1, s2: MSBs of RS1/RS2.
  - FUNCT3, an opcode class (BRANCH 11000, JAL 11011, JALR 11001, OTHER), PRED_TAKEN, IN_TAG.
- Stage B combine (registered into outputs):
  - eq = eq_hi & eq_lo.
  - ltu = ltu_hi | (eq_hi & ltu_lo).
  - lt = (s1 != s2) ? s1 : ltu.
- Direction by opcode class:
  - BRANCH: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu, 010/011 → 0.
  - JAL/JALR: 1 regardless of FUNCT3, including X.
  - OTHER: 0.
- MISPREDICT = BRANCH_TAKEN ^ pred. A non-control op with PRED_TAKEN=1 flags a mispredict.
- FLUSH:
  - At the next edge, vA = vB = 0.
  - An input presented in the flush cycle is discarded.
  - IN_READY is forced 1 during FLUSH.
  - FLUSH has priority over acceptance and over advancement.
  - Data registers may retain stale values.
- Equal operands: BEQ/BGE/BGEU taken; BNE/BLT/BLTU not taken.
- Extreme values: the 0x8000…0 vs 0x7FFF…F boundary resolves correctly, signed and unsigned.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- Defined:
  - BR_COUNT increments on each output handshake whose class is BRANCH/JAL/JALR.
  - MISS_COUNT increments on each output handshake with MISPREDICT=1.
  - Both counters wrap modulo 2^CNT_W, are cleared by RESET, and are unaffected by FLUSH.
- Undefined: BR_COUNT and MISS_COUNT are tied to 0 and no counter flops are generated.

Test Plan:
- XLEN=32, BLT: RS1=0xFFFFFFF8, RS2=0x0000000C, PRED_TAKEN=0, OUT_READY=1 → 2 cycles later OUT_VALID=1, BRANCH_TAKEN=1, MISPREDICT=1. Same operands with BLTU → BRANCH_TAKEN=0, MISPREDICT=0.
- Back-to-back: 4 BEQ inputs, tags 1..4 (RS1=RS2=0x1234 on even tags, unequal on odd), OUT_READY=1 → tags 1..4 out on consecutive cycles with taken pattern 0,1,0,1 and IN_READY constantly 1.
- Stall: fill the pipe with 3 inputs, OUT_READY=0 for 5 cycles → IN_READY=0 after 2 accepted; outputs held stable. OUT_READY=1 → all 3 drain in order and none is lost.
- FLUSH with 2 transactions in flight plus one presented → OUT_VALID=0 next cycle; no flushed tag ever appears; the next input appears 2 cycles after acceptance.
- JAL with FUNCT3=X, PRED_TAKEN=1 → BRANCH_TAKEN=1, MISPREDICT=0. OPCODE 01100 (OP) with PRED_TAKEN=1 → BRANCH_TAKEN=0, MISPREDICT=1.
- RESET asserted mid-stall → OUT_VALID drops immediately, asynchronously. With the macro defined, BR_COUNT = MISS_COUNT = 0 afterward; after the first scenario above, BR_COUNT=2 and MISS_COUNT=1.
